// File: rtl/drum_arb_pkg.sv
// ============================================================================
// Module      : drum_arb_pkg
// Description : Shared constants and helpers for the drum multiplier arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package drum_arb_pkg;

  // Default drum geometry: truncation width and operand widths.
  localparam int DRUM_K_DEF = 6;
  localparam int DRUM_N_DEF = 7;
  localparam int DRUM_M_DEF = 7;

  // Width of each per-requester grant counter.
  localparam int PERF_CNT_W = 16;

  // Bit offset of lane idx inside a packed vector of w-bit lanes.
  function automatic int lane_off(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/drum.sv
// ============================================================================
// Module      : drum
// Description : Combinational DRUM approximate multiplier. Operands are made
//               positive by one's complement, each magnitude is cut to K bits
//               below its leading one with the LSB forced to 1, the K x K
//               product is shifted back, and the sign is re-applied by one's
//               complement. Magnitudes narrower than K bits multiply exactly.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module drum #(
  parameter int K = 6,
  parameter int N = 7,
  parameter int M = 7
) (
  input  logic [N-1:0]   a_i,
  input  logic [M-1:0]   b_i,
  output logic [N+M-1:0] r_o
);

  localparam int SAW = $clog2(N) + 1;
  localparam int SBW = $clog2(M) + 1;

  logic [N-1:0]   a_mag;
  logic [M-1:0]   b_mag;
  logic [K-1:0]   a_t;
  logic [K-1:0]   b_t;
  logic [SAW-1:0] a_sh;
  logic [SBW-1:0] b_sh;
  logic [2*K-1:0] prod;
  logic [N+M-1:0] r_mag;
  logic           neg;

  // Leading-one truncation of operand A; the highest set bit wins.
  always_comb begin
    a_mag = a_i[N-1] ? ~a_i : a_i;
    a_t   = a_mag[K-1:0];
    a_sh  = '0;
    for (int i = K; i < N; i++) begin
      if (a_mag[i]) begin
        a_t  = {a_mag[i -: K-1], 1'b1};
        a_sh = SAW'(i - K + 1);
      end
    end
  end

  // Leading-one truncation of operand B; the highest set bit wins.
  always_comb begin
    b_mag = b_i[M-1] ? ~b_i : b_i;
    b_t   = b_mag[K-1:0];
    b_sh  = '0;
    for (int i = K; i < M; i++) begin
      if (b_mag[i]) begin
        b_t  = {b_mag[i -: K-1], 1'b1};
        b_sh = SBW'(i - K + 1);
      end
    end
  end

  assign prod  = a_t * b_t;
  assign r_mag = (N+M)'(prod) << (int'(a_sh) + int'(b_sh));
  assign neg   = a_i[N-1] ^ b_i[M-1];
  assign r_o   = neg ? ~r_mag : r_mag;

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Searches upward from the
//               pointer with wrap-around and returns a one-hot grant plus the
//               encoded index of the winner. No grant when disabled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic            en_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  id_o
);

  logic found;
  int   idx;

  // First requesting lane at or above the pointer, wrapping past NREQ-1.
  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (en_i && !found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        id_o       = IDW'(idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/drum_mul_arbiter.sv
// ============================================================================
// Module      : drum_mul_arbiter
// Description : Round-robin sharing of one drum multiplier among NREQ
//               requesters through a two-stage pipeline (operand register,
//               then result register) with one id-tagged response channel.
//               Optional macro DRUM_ARB_PERF_EN adds per-requester saturating
//               grant counters on output perf_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module drum_mul_arbiter
  import drum_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int K    = DRUM_K_DEF,
  parameter  int N    = DRUM_N_DEF,
  parameter  int M    = DRUM_M_DEF,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*M-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N+M-1:0]    rsp_r
`ifdef DRUM_ARB_PERF_EN
  ,
  output logic [NREQ*PERF_CNT_W-1:0] perf_cnt
`endif
);

  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  logic            s1_valid_q;
  logic [N-1:0]    s1_a_q;
  logic [M-1:0]    s1_b_q;
  logic [IDW-1:0]  s1_id_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  ptr_d;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [N+M-1:0]  rsp_r_q;

  logic            s1_adv;
  logic            s2_adv;
  logic            arb_en;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_any;
  logic [N-1:0]    gnt_a;
  logic [M-1:0]    gnt_b;
  logic [N+M-1:0]  drum_r;

  assign s2_adv  = !rsp_valid_q || rsp_ready;
  assign s1_adv  = !s1_valid_q || s2_adv;
  assign arb_en  = s1_adv && !rst;
  assign gnt_any = |gnt;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .req_i (req_valid),
    .en_i  (arb_en),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .id_o  (gnt_id)
  );

  assign req_ready = gnt;

  // Select the winner's operands and move the pointer just past it.
  always_comb begin
    gnt_a = req_a[lane_off(int'(gnt_id), N) +: N];
    gnt_b = req_b[lane_off(int'(gnt_id), M) +: M];
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
    end
  end

  // Stage 1: operand register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      ptr_q      <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (s1_adv) begin
        s1_valid_q <= gnt_any;
        if (gnt_any) begin
          s1_a_q  <= gnt_a;
          s1_b_q  <= gnt_b;
          s1_id_q <= gnt_id;
        end
      end
    end
  end

  drum #(
    .K (K),
    .N (N),
    .M (M)
  ) u_drum (
    .a_i (s1_a_q),
    .b_i (s1_b_q),
    .r_o (drum_r)
  );

  // Stage 2: result register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_r_q     <= '0;
    end else if (s2_adv) begin
      rsp_valid_q <= s1_valid_q;
      rsp_id_q    <= s1_id_q;
      rsp_r_q     <= drum_r;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_r     = rsp_r_q;

`ifdef DRUM_ARB_PERF_EN
  generate
    for (genvar g = 0; g < NREQ; g++) begin : g_perf_lane
      logic [PERF_CNT_W-1:0] cnt_q;

      // Count grants to this lane, sticking at all-ones.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
        end else if (gnt[g] && (cnt_q != {PERF_CNT_W{1'b1}})) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      assign perf_cnt[g*PERF_CNT_W +: PERF_CNT_W] = cnt_q;
    end
  endgenerate
`endif

endmodule

`default_nettype wire
